// File: rtl/fetch_unit.sv
// fetch_unit: MIPS instruction fetch stage.
// Holds the PC, fetches one word per instruction over a req/ack handshake,
// presents it to decode over valid/ready, and selects the next PC
// (jump > branch > sequential) when decode accepts the instruction.
module fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic [31:0] instr,
   output logic        instr_valid,
   input  logic        instr_ready,
   output logic [31:0] pc,
   output logic [31:0] pcplus4,
   input  logic        pcsrc,
   input  logic [31:0] pcbranch,
   input  logic        jump,
   output logic [31:0] icount
);

   // Reset PC is always word aligned; the low two bits of the parameter are dropped.
   localparam logic [31:0] RESET_PC_W = RESET_PC & 32'hFFFF_FFFC;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FETCH = 2'd1,
      ST_HOLD  = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] instr_q, instr_d;
   logic [31:0] icount_q, icount_d;
   logic [31:0] pc_next;
   logic        capture;
   logic        handshake;

   assign pcplus4   = pc_q + 32'd4;
   assign capture   = (state_q == ST_FETCH) && imem_ack;
   assign handshake = (state_q == ST_HOLD) && instr_ready;

   // State register and datapath flops, cleared asynchronously by rst_n.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         pc_q     <= RESET_PC_W;
         instr_q  <= 32'd0;
         icount_q <= 32'd0;
      end else begin
         state_q  <= state_d;
         pc_q     <= pc_d;
         instr_q  <= instr_d;
         icount_q <= icount_d;
      end
   end

   // Next-state logic: IDLE -> FETCH -> (ack) HOLD -> (ready) FETCH.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:  state_d = ST_FETCH;
         ST_FETCH: if (imem_ack)    state_d = ST_HOLD;
         ST_HOLD:  if (instr_ready) state_d = ST_FETCH;
         default:  state_d = ST_IDLE;
      endcase
   end

   // Next-PC select: jump wins over a taken branch, otherwise sequential.
   always_comb begin
      pc_next = pcplus4;
      if (jump) begin
         pc_next = {pcplus4[31:28], instr_q[25:0], 2'b00};
      end else if (pcsrc) begin
         pc_next = pcbranch & 32'hFFFF_FFFC;
      end
   end

   // Datapath updates: instr only on capture, pc/icount only on the decode handshake.
   always_comb begin
      instr_d  = instr_q;
      pc_d     = pc_q;
      icount_d = icount_q;
      if (capture) begin
         instr_d = imem_rdata;
      end
      if (handshake) begin
         pc_d     = pc_next;
         icount_d = icount_q + 32'd1;
      end
   end

   // Outputs decoded from state only, so neither handshake input feeds through.
   always_comb begin
      imem_req    = (state_q == ST_FETCH);
      instr_valid = (state_q == ST_HOLD);
   end

   assign imem_addr = pc_q;
   assign pc        = pc_q;
   assign instr     = instr_q;
   assign icount    = icount_q;

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed plus randomized checks of fetch_unit against a
// transaction-level model (expected PC, instruction and retire count).
module tb_fetch_unit;

   localparam logic [31:0] RST_PC = 32'h0040_0000;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic [31:0] instr;
   logic        instr_valid;
   logic        instr_ready;
   logic [31:0] pc;
   logic [31:0] pcplus4;
   logic        pcsrc;
   logic [31:0] pcbranch;
   logic        jump;
   logic [31:0] icount;

   int n_cmp  = 0;
   int n_mism = 0;

   // Reference model state
   logic [31:0] exp_pc;
   logic [31:0] exp_instr;
   logic [31:0] exp_icount;

   fetch_unit #(.RESET_PC(RST_PC)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .imem_req   (imem_req),
      .imem_addr  (imem_addr),
      .imem_ack   (imem_ack),
      .imem_rdata (imem_rdata),
      .instr      (instr),
      .instr_valid(instr_valid),
      .instr_ready(instr_ready),
      .pc         (pc),
      .pcplus4    (pcplus4),
      .pcsrc      (pcsrc),
      .pcbranch   (pcbranch),
      .jump       (jump),
      .icount     (icount)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_cmp++;
      assert (obs === expv) else begin
         n_mism++;
         $error("FAIL %s: observed %h expected %h", tag, obs, expv);
      end
   endtask

   // Randomize the inputs that must be ignored outside their sampling points.
   task automatic scramble_dont_care();
      pcsrc    = 1'($urandom);
      jump     = 1'($urandom);
      pcbranch = $urandom;
   endtask

   // One full instruction: fetch with wait_n wait cycles, hold for stall_n
   // cycles, then handshake with the given jump/branch controls.
   task automatic fetch_txn(input int wait_n, input logic [31:0] data, input int stall_n,
                            input logic j, input logic b, input logic [31:0] tgt);
      logic [31:0] p4;
      check("fetch_req",   {31'd0, imem_req},    32'd1);
      check("fetch_addr",  imem_addr,            exp_pc);
      check("fetch_valid", {31'd0, instr_valid}, 32'd0);
      for (int i = 0; i < wait_n; i++) begin
         imem_ack    = 1'b0;
         imem_rdata  = $urandom;
         instr_ready = 1'($urandom);
         scramble_dont_care();
         @(negedge clk);
         check("wait_req",   {31'd0, imem_req}, 32'd1);
         check("wait_addr",  imem_addr,         exp_pc);
         check("wait_instr", instr,             exp_instr);
      end
      imem_ack    = 1'b1;
      imem_rdata  = data;
      instr_ready = 1'($urandom);
      scramble_dont_care();
      @(negedge clk);
      exp_instr = data;
      for (int i = 0; i < stall_n; i++) begin
         instr_ready = 1'b0;
         imem_ack    = 1'($urandom);
         imem_rdata  = $urandom;
         scramble_dont_care();
         check("hold_valid", {31'd0, instr_valid}, 32'd1);
         check("hold_req",   {31'd0, imem_req},    32'd0);
         check("hold_instr", instr,                exp_instr);
         check("hold_pc",    pc,                   exp_pc);
         @(negedge clk);
      end
      check("hs_valid",   {31'd0, instr_valid}, 32'd1);
      check("hs_instr",   instr,                exp_instr);
      check("hs_pc",      pc,                   exp_pc);
      check("hs_pcplus4", pcplus4,              exp_pc + 32'd4);
      check("hs_icount",  icount,               exp_icount);
      instr_ready = 1'b1;
      imem_ack    = 1'($urandom);
      imem_rdata  = $urandom;
      jump        = j;
      pcsrc       = b;
      pcbranch    = tgt;
      @(negedge clk);
      p4 = exp_pc + 32'd4;
      if (j)      exp_pc = {p4[31:28], exp_instr[25:0], 2'b00};
      else if (b) exp_pc = tgt & 32'hFFFF_FFFC;
      else        exp_pc = p4;
      exp_icount++;
      imem_ack    = 1'b0;
      instr_ready = 1'b0;
      scramble_dont_care();
      check("next_valid",  {31'd0, instr_valid}, 32'd0);
      check("next_icount", icount,               exp_icount);
      $display("txn wait=%0d stall=%0d j=%0d b=%0d instr=%h -> pc=%h icount=%0d",
               wait_n, stall_n, j, b, exp_instr, pc, icount);
   endtask

   initial begin
      rst_n       = 1'b0;
      imem_ack    = 1'b0;
      imem_rdata  = 32'd0;
      instr_ready = 1'b0;
      pcsrc       = 1'b0;
      jump        = 1'b0;
      pcbranch    = 32'd0;
      exp_pc      = RST_PC;
      exp_instr   = 32'd0;
      exp_icount  = 32'd0;

      // Reset held for three cycles
      repeat (3) begin
         @(negedge clk);
         check("rst_pc",     pc,                   RST_PC);
         check("rst_req",    {31'd0, imem_req},    32'd0);
         check("rst_valid",  {31'd0, instr_valid}, 32'd0);
         check("rst_icount", icount,               32'd0);
         check("rst_instr",  instr,                32'd0);
      end
      rst_n = 1'b1;
      @(negedge clk);
      check("first_req", {31'd0, imem_req}, 32'd1);

      // Branch from the reset PC to 0 (low target bits must be masked off)
      fetch_txn(0, 32'h1234_5678, 0, 1'b0, 1'b1, 32'h0000_0003);
      // Sequential zero-wait stream: 0x0, 0x4, 0x8, 0xC
      for (int k = 0; k < 4; k++) begin
         fetch_txn(0, $urandom, 0, 1'b0, 1'b0, 32'd0);
      end
      check("seq_pc", pc, 32'h0000_0010);
      // Wait states, backpressure with spurious acks, branch 0x43 -> 0x40
      fetch_txn(3, 32'hDEAD_BEEF, 5, 1'b0, 1'b1, 32'h0000_0043);
      check("branch_addr", imem_addr, 32'h0000_0040);
      // Move to 0x1000_0008, then jump beats branch
      fetch_txn(1, $urandom, 1, 1'b0, 1'b1, 32'h1000_0008);
      fetch_txn(0, 32'h0800_0100, 2, 1'b1, 1'b1, 32'h0000_0200);
      check("jump_addr", imem_addr, 32'h1000_0400);
      // PC wrap at the top of the address space
      fetch_txn(0, $urandom, 0, 1'b0, 1'b1, 32'hFFFF_FFFC);
      fetch_txn(2, $urandom, 0, 1'b0, 1'b0, 32'd0);
      check("wrap_addr", imem_addr, 32'h0000_0000);

      // Randomized traffic
      for (int k = 0; k < 40; k++) begin
         fetch_txn(int'($urandom_range(0, 3)), $urandom, int'($urandom_range(0, 3)),
                   ($urandom_range(0, 7) == 0), 1'($urandom), $urandom);
      end

      // Asynchronous reset during a FETCH wait, with ack arriving that cycle
      imem_ack   = 1'b0;
      @(negedge clk);
      check("pre_rst_req", {31'd0, imem_req}, 32'd1);
      imem_ack   = 1'b1;
      imem_rdata = 32'hCAFE_F00D;
      #2 rst_n = 1'b0;
      #1;
      check("arst_req",    {31'd0, imem_req},    32'd0);
      check("arst_valid",  {31'd0, instr_valid}, 32'd0);
      check("arst_pc",     pc,                   RST_PC);
      check("arst_icount", icount,               32'd0);
      check("arst_instr",  instr,                32'd0);
      exp_pc     = RST_PC;
      exp_instr  = 32'd0;
      exp_icount = 32'd0;
      @(negedge clk);
      check("arst_instr2", instr, 32'd0);
      imem_ack = 1'b0;
      rst_n    = 1'b1;
      @(negedge clk);
      check("rerun_req", {31'd0, imem_req}, 32'd1);
      fetch_txn(1, $urandom, 1, 1'b0, 1'b0, 32'd0);
      check("rerun_pc", pc, RST_PC + 32'd4);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mism);
      $finish;
   end

endmodule
